shift_rotate_unit: RTL
======================

# shift_rotate_unit

Parametrised, multi-cycle shift/rotate execution unit for the CPU datapath. It generalises the single-mode ROTR path into one block that performs five operations (SHL, SHR, SHRA, ROL, ROR) on a WIDTH-bit operand, with a start/done handshake. It sits beside the ALU, fed from the Y register and the bus; its result is captured into Z by the datapath when `done` is high. It processes one bit of the shift amount per clock, giving a fixed latency of log2(WIDTH) cycles.

## Interface
- `WIDTH`, default 32: operand/result width; power of two, ≥4.
- `LOG2W`, default $clog2(WIDTH): amount bits used, and the number of shift cycles.

- `Clock`  in  1  sole clock; all state updates on its rising edge.
- `Clear`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  3  operation: 0 SHL, 1 SHR, 2 SHRA, 3 ROL, 4 ROR; 5–7 reserved.
- `a`  in  WIDTH  operand (Y).
- `amt`  in  WIDTH  shift amount (bus value); only `amt[LOG2W-1:0]` used.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  WIDTH  shifted value; held until the next accepted start.
- `zero`  out  1  `result == 0`; updated together with `result`.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE, step=0, working register=0, `result`=0, `zero`=1, `busy`=0, `done`=0.
- IDLE: `start`=1 → latch `a` into the working register, latch `op` and `amt[LOG2W-1:0]`, set step=0, go to SHIFT. `start`=0 → stay.
- SHIFT: apply stage `step` to the working register: if `amt_l[step]`, shift/rotate by 2^step per latched op; otherwise pass through. Increment step. After stage LOG2W-1, write the final value to `result`/`zero` and go to DONE.
- DONE: `done`=1 for this cycle only. `start`=1 → accept as in IDLE and go directly to SHIFT. Otherwise go to IDLE.
- Op rules:
  - SHL/SHR fill with 0.
  - SHRA fills with the operand's original MSB at every stage.
  - ROL/ROR wrap bits around.
  - Amount 0 → `result`=`a` for all ops, with full latency.
- Reserved op (5–7): all stages pass through; `result`=`a`.
- Inputs `a`, `op` and `amt` are not used after acceptance. They may change freely while `busy`.
- `start` while in SHIFT is ignored and is not queued.
- `Clear` in any state takes priority over `start`. It forces the reset values on the next edge, and no `done` pulse is issued for the aborted operation.

## Timing
- Edge E0 samples `start` → SHIFT. Edges E1..E_LOG2W perform the stages. At edge E_LOG2W, `result` is updated and the state becomes DONE.
- `busy` is high in the LOG2W cycles after E0. `done` is high in the single cycle after E_LOG2W.
- Latency from the start edge to `done`: LOG2W cycles (5 for WIDTH=32).
- Back-to-back: `start` held high in the DONE cycle gives throughput of one result every LOG2W+1 cycles.
- `result`/`zero` are registered outputs. They change only at the final-stage edge or on `Clear`.

## Structure
- Package `shift_pkg`: op encodings (`OP_SHL`…`OP_ROR`), the state enum `{S_IDLE, S_SHIFT, S_DONE}`, and the op width constant (3).
- Sub-module `shift_stage` (combinational, parametrised by WIDTH): inputs are value, distance 2^k (as a runtime index), enable, op and fill bit; output is the value after the stage. It is instantiated once and indexed by `step`. The top level holds the FSM, step counter and registers.

## Test plan
- WIDTH=32, `a`=12, `amt`=3, ROR → `result`=0x80000001 and `done` exactly 5 cycles after the start edge; `busy` high for those 5 cycles.
- `a`=0x80000010, `amt`=4: SHRA → 0xF8000001; SHR → 0x08000001; SHL → 0x00000100; ROL → 0x00000108.
- `amt`=32 (low 5 bits 0) with `a`=0x1A920000, ROR → `result`=0x1A920000, `zero`=0; then SHL with `a`=1, `amt`=31 followed by SHL with `a`=2, `amt`=31 → second result is 0 with `zero`=1.
- `start` pulsed during SHIFT and `a` changed mid-operation → first result unaffected; no extra `done`.
- `start` held high through DONE → the second operation is accepted with no IDLE cycle, and `done` pulses are 6 cycles apart.
- `Clear` asserted at step 2 → next cycle IDLE, `result`=0, `zero`=1, `busy`=0, and no `done` for the aborted operation.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Operation encodings, FSM states and shared widths for the
//               shift/rotate execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_SHL  = 3'd0;
    localparam op_t OP_SHR  = 3'd1;
    localparam op_t OP_SHRA = 3'd2;
    localparam op_t OP_ROL  = 3'd3;
    localparam op_t OP_ROR  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Reserved encodings (5..7) leave the operand untouched.
    function automatic logic op_is_active(input op_t op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SHRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rotate_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_rotate_unit_if
// Description : Start/done request and result bundle of the shift/rotate unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_rotate_unit_if #(
    parameter int WIDTH = 32
) ();
    import shift_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, op, a, amt,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, a, amt,
        output busy, done, result, zero
    );

endinterface
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One combinational shift/rotate stage by 2^i_dist_idx bits.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] i_value,
    input  wire logic [LOG2W-1:0] i_dist_idx,
    input  wire logic             i_enable,
    input  wire op_t              i_op,
    input  wire logic             i_fill,
    output logic      [WIDTH-1:0] o_value
);

    logic [LOG2W:0]   w_dist;
    logic [LOG2W:0]   w_comp;
    logic [WIDTH-1:0] w_fill_mask;

    // Distance never exceeds WIDTH/2, so the complementary rotate distance
    // stays strictly inside the word.
    assign w_dist      = (LOG2W+1)'(1) << i_dist_idx;
    assign w_comp      = (LOG2W+1)'(WIDTH) - w_dist;
    assign w_fill_mask = ~({WIDTH{1'b1}} >> w_dist);

    always_comb begin
        o_value = i_value;
        if (i_enable && op_is_active(i_op)) begin
            case (i_op)
                OP_SHL:  o_value = i_value << w_dist;
                OP_SHR:  o_value = i_value >> w_dist;
                OP_SHRA: o_value = (i_value >> w_dist) | (i_fill ? w_fill_mask : '0);
                OP_ROL:  o_value = (i_value << w_dist) | (i_value >> w_comp);
                OP_ROR:  o_value = (i_value >> w_dist) | (i_value << w_comp);
                default: o_value = i_value;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_rotate_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_rotate_unit
// Description : Multi-cycle SHL/SHR/SHRA/ROL/ROR unit, one amount bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  wire logic        Clock,
    input  wire logic        Clear,
    shift_rotate_unit_if.slave bus
);

    state_t           r_state;
    logic [LOG2W-1:0] r_step;
    logic [WIDTH-1:0] r_work;
    op_t              r_op;
    logic [LOG2W-1:0] r_amt;
    logic             r_fill;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    state_t           w_state_nxt;
    logic [LOG2W-1:0] w_step_nxt;
    logic [WIDTH-1:0] w_work_nxt;
    op_t              w_op_nxt;
    logic [LOG2W-1:0] w_amt_nxt;
    logic             w_fill_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_zero_nxt;
    logic             w_accept;
    logic             w_last_step;
    logic [WIDTH-1:0] w_stage_out;
    logic             w_unused_amt;

    assign w_unused_amt = ^bus.amt[WIDTH-1:LOG2W];
    assign w_last_step  = (r_step == LOG2W'(LOG2W-1));

    // A single stage is reused every cycle; r_step selects its distance.
    shift_stage #(
        .WIDTH (WIDTH),
        .LOG2W (LOG2W)
    ) u_stage (
        .i_value    (r_work),
        .i_dist_idx (r_step),
        .i_enable   (r_amt[r_step]),
        .i_op       (r_op),
        .i_fill     (r_fill),
        .o_value    (w_stage_out)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_work   <= '0;
            r_op     <= OP_SHL;
            r_amt    <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_work   <= w_work_nxt;
            r_op     <= w_op_nxt;
            r_amt    <= w_amt_nxt;
            r_fill   <= w_fill_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_work_nxt   = r_work;
        w_op_nxt     = r_op;
        w_amt_nxt    = r_amt;
        w_fill_nxt   = r_fill;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;
        w_accept     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
            end
            S_SHIFT: begin
                w_work_nxt = w_stage_out;
                w_step_nxt = r_step + LOG2W'(1);
                if (w_last_step) begin
                    w_result_nxt = w_stage_out;
                    w_zero_nxt   = (w_stage_out == '0);
                    w_step_nxt   = '0;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                w_accept    = bus.start;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The operand MSB is captured once so SHRA sign-fills from the
        // original value at every stage.
        if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_step_nxt  = '0;
            w_work_nxt  = bus.a;
            w_op_nxt    = bus.op;
            w_amt_nxt   = bus.amt[LOG2W-1:0];
            w_fill_nxt  = bus.a[WIDTH-1];
        end
    end

    assign bus.busy   = (r_state == S_SHIFT);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.zero   = r_zero;

endmodule
`default_nettype wire
